// File: rtl/perf_counter_bank.sv
// Multi-channel cycle-counter bank driven by 32-bit command words, with per-channel
// run state, sticky overflow and snapshot shadows. Define PERF_CNT_SATURATE_EN to saturate instead of wrap.
module perf_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       trigger,
    input  logic [3:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] running,
    output logic [NUM_CH-1:0] overflow,
    output logic              cmd_err
);

    localparam logic [3:0] OP_START    = 4'd1;
    localparam logic [3:0] OP_STOP     = 4'd2;
    localparam logic [3:0] OP_CLEAR    = 4'd3;
    localparam logic [3:0] OP_SNAPSHOT = 4'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        STOPPED  = 2'd2
    } ch_state_t;

    logic [3:0] opcode;
    logic [3:0] ch_idx;
    logic       bcast;
    logic       op_valid;
    logic       idx_bad;
    logic       unused_trigger_bits;

    assign opcode   = trigger[3:0];
    assign ch_idx   = trigger[11:8];
    assign bcast    = trigger[15];
    assign op_valid = (opcode >= OP_START) && (opcode <= OP_SNAPSHOT);
    assign idx_bad  = {1'b0, ch_idx} >= 5'(NUM_CH);
    assign unused_trigger_bits = ^{trigger[31:16], trigger[14:12], trigger[7:4]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= op_valid && !bcast && idx_bad;
        end
    end

    logic [CNT_W-1:0] shadow_vec [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ch_state_t        state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [CNT_W-1:0] shadow_reg;
            logic             ovf_reg, ovf_next;
            logic             hit;
            logic             do_start, do_stop, do_clear, do_snap, do_inc;

            // An out-of-range index never matches any channel, so bad commands fall through here.
            assign hit      = op_valid && (bcast || (ch_idx == 4'(gi)));
            assign do_start = hit && (opcode == OP_START);
            assign do_stop  = hit && (opcode == OP_STOP);
            assign do_clear = hit && (opcode == OP_CLEAR);
            assign do_snap  = hit && (opcode == OP_SNAPSHOT);
            assign do_inc   = do_start || ((state_reg == COUNTING) && !do_stop && !do_clear);

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                ovf_next   = ovf_reg;
                case (state_reg)
                    IDLE:     if (do_start) state_next = COUNTING;
                    COUNTING: if (do_stop)  state_next = STOPPED;
                    STOPPED:  if (do_start) state_next = COUNTING;
                    default:  state_next = IDLE;
                endcase
                if (do_clear) begin
                    cnt_next = '0;
                    ovf_next = 1'b0;
                end else if (do_inc) begin
                    if (cnt_reg == '1) begin
                        ovf_next = 1'b1;
`ifdef PERF_CNT_SATURATE_EN
                        cnt_next = cnt_reg;
`else
                        cnt_next = '0;
`endif
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_reg  <= IDLE;
                    cnt_reg    <= '0;
                    ovf_reg    <= 1'b0;
                    shadow_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    ovf_reg   <= ovf_next;
                    // Shadow captures the value before this edge's increment or clear.
                    if (do_snap) begin
                        shadow_reg <= cnt_reg;
                    end
                end
            end

            assign running[gi]    = (state_reg == COUNTING);
            assign overflow[gi]   = ovf_reg;
            assign shadow_vec[gi] = shadow_reg;
        end
    endgenerate

    logic [CNT_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == 4'(i)) begin
                rd_mux = shadow_vec[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

endmodule
